// File: rtl/sound_post_filter.sv
// Audio post-processing stage: DC-blocking high-pass, click-free mute/unmute gain ramp
// and output saturation, sequenced over six system-clock states per 48 kHz sample.
module sound_post_filter #(
    parameter int DC_SHIFT  = 8,
    parameter int RAMP_STEP = 4,
    parameter int BYPASS_DC = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_48KHz_en,
    input  logic [15:0] audio_in,
    input  logic        mute_req,
    output logic [15:0] audio_out,
    output logic        out_valid,
    output logic        mute_done,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIFF = 3'd1,
        LEAK = 3'd2,
        CLIP = 3'd3,
        GAIN = 3'd4,
        OUT  = 3'd5
    } state_t;

    localparam logic [8:0] RAMP_UNITY = 9'd256;
    localparam logic [8:0] RAMP_INC   = 9'(RAMP_STEP);

    function automatic logic signed [17:0] sat18(input logic signed [19:0] v);
        logic signed [17:0] r;
        if (v > 20'sd131071) begin
            r = 18'sh1FFFF;
        end else if (v < -20'sd131072) begin
            r = 18'sh20000;
        end else begin
            r = v[17:0];
        end
        return r;
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [26:0] v);
        logic signed [15:0] r;
        if (v > 27'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -27'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    state_t             state_r;
    logic signed [15:0] x_cur_r;
    logic signed [15:0] x_prev_r;
    logic signed [17:0] y_prev_r;
    logic signed [17:0] d_r;
    logic signed [19:0] acc_r;
    logic signed [17:0] y_r;
    logic        [8:0]  ramp_r;
    logic        [15:0] audio_out_r;
    logic               out_valid_r;
    logic               overrun_r;

    logic signed [17:0] d_s;
    logic signed [17:0] leak_s;
    logic signed [19:0] acc_s;
    logic signed [17:0] y_s;
    logic signed [26:0] p_s;
    logic signed [26:0] q_s;
    logic signed [15:0] q_sat_s;

    // Datapath for the current stage; each result is captured by the FSM in its own state.
    always_comb begin
        d_s     = {{2{x_cur_r[15]}}, x_cur_r} - {{2{x_prev_r[15]}}, x_prev_r};
        leak_s  = y_prev_r >>> DC_SHIFT;
        acc_s   = {{2{d_r[17]}}, d_r} + {{2{y_prev_r[17]}}, y_prev_r}
                - {{2{leak_s[17]}}, leak_s};
        if (BYPASS_DC != 0) begin
            y_s = {{2{x_cur_r[15]}}, x_cur_r};
        end else begin
            y_s = sat18(acc_r);
        end
        p_s     = 27'(y_r) * 27'($signed({1'b0, ramp_r}));
        q_s     = p_s >>> 8;
        q_sat_s = sat16(q_s);
    end

    // Sample sequencer: one stage per clock, outputs and filter history registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            x_cur_r     <= 16'sd0;
            x_prev_r    <= 16'sd0;
            y_prev_r    <= 18'sd0;
            d_r         <= 18'sd0;
            acc_r       <= 20'sd0;
            y_r         <= 18'sd0;
            ramp_r      <= 9'd0;
            audio_out_r <= 16'd0;
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (clk_48KHz_en && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (clk_48KHz_en) begin
                        x_cur_r <= audio_in;
                        state_r <= DIFF;
                    end
                end
                DIFF: begin
                    d_r     <= d_s;
                    state_r <= LEAK;
                end
                LEAK: begin
                    acc_r   <= acc_s;
                    state_r <= CLIP;
                end
                CLIP: begin
                    y_r      <= y_s;
                    y_prev_r <= y_s;
                    x_prev_r <= x_cur_r;
                    state_r  <= GAIN;
                end
                GAIN: begin
                    // Registering here makes the pulse visible during the OUT state itself.
                    audio_out_r <= q_sat_s;
                    out_valid_r <= 1'b1;
                    state_r     <= OUT;
                end
                OUT: begin
                    if (mute_req) begin
                        if (ramp_r <= RAMP_INC) begin
                            ramp_r <= 9'd0;
                        end else begin
                            ramp_r <= ramp_r - RAMP_INC;
                        end
                    end else begin
                        if (ramp_r >= (RAMP_UNITY - RAMP_INC)) begin
                            ramp_r <= RAMP_UNITY;
                        end else begin
                            ramp_r <= ramp_r + RAMP_INC;
                        end
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign audio_out = audio_out_r;
    assign out_valid = out_valid_r;
    assign overrun   = overrun_r;
    assign mute_done = (ramp_r == 9'd0);

endmodule

// File: tb/tb_sound_post_filter.sv
// Directed bench for sound_post_filter: latency, DC blocking, saturation, mute ramp,
// overrun and asynchronous reset, with hand-derived expected samples.
module tb_sound_post_filter;

    logic               clk;
    logic               rst;
    logic               clk_48KHz_en;
    logic signed [15:0] audio_in;
    logic               mute_req;
    logic signed [15:0] audio_out;
    logic               out_valid;
    logic               mute_done;
    logic               overrun;

    int checks;
    int failures;

    sound_post_filter dut (
        .clk          (clk),
        .rst          (rst),
        .clk_48KHz_en (clk_48KHz_en),
        .audio_in     (audio_in),
        .mute_req     (mute_req),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .mute_done    (mute_done),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Strobe one sample, wait (bounded) for out_valid, check latency and the one-cycle pulse.
    task automatic run_sample(input logic signed [15:0] x, output logic signed [15:0] y);
        int lat;
        @(negedge clk);
        audio_in     = x;
        clk_48KHz_en = 1'b1;
        @(negedge clk);
        clk_48KHz_en = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 5);
        y = audio_out;
        @(negedge clk);
        check("valid_pulse", out_valid, 0);
    endtask

    initial begin
        logic signed [15:0] y;
        int lat;
        int seen;
        int ramp_m;
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        clk_48KHz_en = 1'b0;
        audio_in     = 16'sd0;
        mute_req     = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_audio_out", audio_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_mute_done", mute_done, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 64 silent samples ramp the gain from 0 up to unity.
        for (int k = 0; k < 64; k++) begin
            run_sample(16'sd0, y);
            check("zero_out", y, 0);
            check("zero_mute_done", mute_done, 0);
        end
        check("zero_overrun", overrun, 0);

        // Step to 1000 at unity gain, then the DC blocker leaks it away.
        run_sample(16'sd1000, y); check("step0", y, 1000);
        run_sample(16'sd1000, y); check("step1", y, 997);
        run_sample(16'sd1000, y); check("step2", y, 994);
        run_sample(16'sd1000, y); check("step3", y, 991);
        run_sample(16'sd1000, y); check("step4", y, 988);

        // Large swings: internal value -32783 clips low, then +32881 clips high.
        run_sample(-16'sd32768, y); check("sat_neg", y, -32768);
        run_sample(16'sd32767, y);  check("sat_pos", y, 32767);
        run_sample(16'sd32767, y);  check("after_sat", y, 32753);
        check("pre_overrun", overrun, 0);

        // Second strobe two clocks after the first must be dropped and flagged.
        @(negedge clk);
        audio_in     = 16'sd32767;
        clk_48KHz_en = 1'b1;
        @(negedge clk);
        clk_48KHz_en = 1'b0;
        @(negedge clk);
        audio_in     = -16'sd5;
        clk_48KHz_en = 1'b1;
        @(negedge clk);
        clk_48KHz_en = 1'b0;
        check("overrun_set", overrun, 1);
        lat = 3;
        while (out_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("overrun_latency", lat, 5);
        check("overrun_sample", audio_out, 32626);
        @(negedge clk);
        run_sample(16'sd32767, y); check("post_overrun", y, 32499);
        check("overrun_sticky", overrun, 1);
        check("pre_reset_mute_done", mute_done, 0);

        // Assert reset while the next sample sits in GAIN.
        @(negedge clk);
        audio_in     = 16'sd100;
        clk_48KHz_en = 1'b1;
        @(negedge clk);
        clk_48KHz_en = 1'b0;
        repeat (3) @(negedge clk);
        check("gain_no_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        check("async_audio_out", audio_out, 0);
        check("async_out_valid", out_valid, 0);
        check("async_mute_done", mute_done, 1);
        check("async_overrun", overrun, 0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b1;
            if (out_valid === 1'b1) seen++;
        end
        check("discarded_sample", seen, 0);

        // Constant y=200 (below the leak threshold) exercises the gain ramp up, down, up.
        mute_req = 1'b0;
        for (int k = 0; k < 64; k++) begin
            ramp_m = 4 * k;
            run_sample(16'sd200, y);
            check("unmute_ramp", y, (200 * ramp_m) / 256);
        end
        run_sample(16'sd200, y); check("unity_200", y, 200);
        check("unity_mute_done", mute_done, 0);

        mute_req = 1'b1;
        for (int m = 0; m < 64; m++) begin
            ramp_m = 256 - 4 * m;
            run_sample(16'sd200, y);
            check("mute_ramp", y, (200 * ramp_m) / 256);
            check("mute_done_ramp", mute_done, (m == 63) ? 1 : 0);
        end
        run_sample(16'sd200, y); check("muted0", y, 0);
        run_sample(16'sd200, y); check("muted1", y, 0);
        check("muted_clamp", mute_done, 1);

        mute_req = 1'b0;
        run_sample(16'sd200, y); check("release0", y, 0);
        check("release_mute_done", mute_done, 0);
        run_sample(16'sd200, y); check("release1", y, 3);
        for (int k = 2; k < 63; k++) begin
            run_sample(16'sd200, y);
        end
        run_sample(16'sd200, y); check("release63", y, 196);
        run_sample(16'sd200, y); check("release_unity", y, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sound_post_filter.md
Name: sound_post_filter

Overview:
- Downstream stage of the sound block. Consumes its 16-bit `audio` word at the 48 kHz sample enable.
- Applies a DC-blocking first-order high-pass filter and a click-free mute/unmute gain ramp, then saturates the result.
- Emits one conditioned sample per 48 kHz enable, with a valid strobe, to the platform audio output.
- Processing is sequential (multi-cycle, one shared adder/multiplier) on the system clock.

Parameters:
- DC_SHIFT, 8: leak shift K; pole = 1 - 2^-K.
- RAMP_STEP, 4: gain change per sample, in 1/256 units.
- BYPASS_DC, 0: 1 = skip the high-pass, so y = x.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- clk_48KHz_en  in  1  one-clk sample strobe.
- audio_in  in  16  sample from the sound block; two's complement signed.
- mute_req  in  1  1 = ramp the gain to 0; 0 = ramp the gain to unity.
- audio_out  out  16  conditioned sample, signed.
- out_valid  out  1  one-clk pulse when audio_out updates.
- mute_done  out  1  1 while the gain is 0.
- overrun  out  1  sticky; a strobe arrived while busy.

Behaviour:
- Reset (rst=0, async):
  - audio_out=0, out_valid=0, overrun=0, state=IDLE.
  - x_prev=0, y_prev=0, ramp=0, so mute_done=1.
  - Reset takes effect immediately in any state. A sample in flight is discarded and produces no out_valid.
- Registers:
  - x_prev: 16b signed.
  - y_prev: 18b signed.
  - ramp: 9b unsigned, range 0..256.
- FSM, one state per clk:
  - IDLE: on clk_48KHz_en, capture audio_in into x_cur and go to DIFF.
  - DIFF: d = sext18(x_cur) - sext18(x_prev).
  - LEAK: acc = d + y_prev - (y_prev >>> DC_SHIFT), arithmetic shift.
  - CLIP:
    - y = acc saturated to 18b signed [-131072, 131071].
    - y_prev <= y; x_prev <= x_cur.
    - If BYPASS_DC=1: y = sext18(x_cur).
  - GAIN: p = y * ramp, 27b signed. q = p >>> 8.
  - OUT:
    - audio_out <= q saturated to [-32768, 32767]; out_valid=1 for this one cycle.
    - Ramp update:
      - mute_req=1: ramp <= max(ramp - RAMP_STEP, 0).
      - mute_req=0: ramp <= min(ramp + RAMP_STEP, 256).
    - Return to IDLE.
- Latency: strobe at cycle N, out_valid at cycle N+5. audio_out holds its value between pulses.
- The gain uses the ramp value from before that sample's update. mute_req is sampled only in OUT.
- Overrun: a clk_48KHz_en arriving in any state other than IDLE is dropped and sets overrun=1. overrun clears only on reset.
- Strobe at the OUT cycle: also dropped (FSM not yet in IDLE).
- mute_done is combinational from the ramp register (ramp==0). It updates the cycle after OUT.
- With ramp=256 and y in 16b range, audio_out = y exactly.
- Ramp endpoints clamp; they never wrap past 0 or 256.

Test Plan:
- Reset then 64 strobes, audio_in=0, mute_req=0 -> all outputs 0; ramp reaches 256 after the 64th strobe (mute_done=0 from the 1st update); out_valid exactly 5 clks after each strobe.
- After unity gain, audio_in steps 0->1000 and holds -> audio_out = 1000, 997, 994 (y = y_prev + 0 - (y_prev>>>8)), decaying monotonically toward 0.
- audio_in -32768 held (settled), then 32767 -> internal acc exceeds 16b; audio_out = 32767 saturated; no wrap to negative.
- mute_req=1 at unity gain, constant filtered input -> gain falls 4/256 per sample; mute_done=1 after exactly 64 samples; audio_out=0 thereafter. Release -> ramps back up symmetrically.
- Strobe asserted 2 clks after a previous strobe -> second is ignored, overrun=1 and stays 1; next legal strobe is processed normally.
- rst pulled low during GAIN -> audio_out=0, out_valid never pulses for that sample, ramp=0, mute_done=1 immediately (async, same cycle).
